// File: rtl/ncountdown_timer.sv
`default_nettype none
// ============================================================================
// ncountdown_timer: loadable tick-driven down-counter with one-cycle expiry pulse.
// Optional periodic mode via NCOUNTDOWN_AUTORELOAD_EN. Revision: 1.0
// ============================================================================
module ncountdown_timer #(
  parameter int busSize = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               abort,
  input  logic [busSize-1:0] load_value,
`ifdef NCOUNTDOWN_AUTORELOAD_EN
  input  logic               auto_reload,
`endif
  output logic [busSize-1:0] count,
  output logic               busy,
  output logic               done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [busSize-1:0] c_zero = '0;
  localparam logic [busSize-1:0] c_one  = busSize'(1);

  state_t             state_q, state_d;
  logic [busSize-1:0] count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef NCOUNTDOWN_AUTORELOAD_EN
  logic [busSize-1:0] period_q, period_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= c_zero;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef NCOUNTDOWN_AUTORELOAD_EN
      period_q <= c_zero;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef NCOUNTDOWN_AUTORELOAD_EN
      period_q <= period_d;
`endif
    end
  end

  // Priority: abort > start > tick. Decrement is gated by count, so no wrap.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    done_d   = 1'b0;
`ifdef NCOUNTDOWN_AUTORELOAD_EN
    period_d = period_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
      count_d = c_zero;
    end else if (start) begin
`ifdef NCOUNTDOWN_AUTORELOAD_EN
      period_d = load_value;
`endif
      if (load_value != c_zero) begin
        state_d = S_RUN;
        count_d = load_value;
      end else begin
        state_d = S_IDLE;
        count_d = c_zero;
        done_d  = 1'b1;
      end
    end else if (tick && (state_q == S_RUN)) begin
      if (count_q > c_one) begin
        count_d = count_q - c_one;
      end else if (count_q == c_one) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        count_d = c_zero;
`ifdef NCOUNTDOWN_AUTORELOAD_EN
        if (auto_reload) begin
          state_d = S_RUN;
          count_d = period_q;
        end
`endif
      end
    end
    busy_d = (state_d == S_RUN);
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
`default_nettype wire
